byte_serializer: RTL

//  Parallel-to-serial stage directly upstream of the 8-stage shift register.

---
 rtl/byte_serializer_pkg.sv | 27 ++
 rtl/serializer_fifo.sv | 77 +++++++
 rtl/byte_serializer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/byte_serializer_pkg.sv
// ----------------------------------------------------------------------------
// byte_serializer_pkg
//   Shared definitions for the byte serializer slice:
//     - state_t  : FSM state encoding (S_IDLE, S_SHIFT, S_PARITY, S_GAP)
//     - cnt_width: bit width needed for a counter that holds 0..max_value,
//                  never less than 1 bit
//   S_PARITY is only ever entered when BYTE_SERIALIZER_PARITY_EN is defined.
// ----------------------------------------------------------------------------
package byte_serializer_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    // A counter that only ever needs to reach max_value still needs one bit
    // when max_value is 0 or 1, so clamp the result to at least 1.
    function automatic int cnt_width(input int max_value);
        if (max_value < 2) begin
            return 1;
        end
        return $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/serializer_fifo.sv
// ----------------------------------------------------------------------------
// serializer_fifo
//   Synchronous FIFO, DATA_W bits wide and DEPTH entries deep, with a
//   registered occupancy count. Read data is the word at the head of the
//   FIFO and is valid whenever empty is low.
//   Ports:
//     clk      in   1          rising-edge clock
//     reset    in   1          synchronous active-high reset (flushes FIFO)
//     push     in   1          write wr_data (ignored while full)
//     wr_data  in   DATA_W     word to write
//     pop      in   1          drop the head word (ignored while empty)
//     rd_data  out  DATA_W     head word
//     full     out  1          count == DEPTH
//     empty    out  1          count == 0
//     count    out  AW+1       number of stored words
// ----------------------------------------------------------------------------
module serializer_fifo
    import byte_serializer_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] COUNT_FULL = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == COUNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/byte_serializer.sv
// ----------------------------------------------------------------------------
// byte_serializer
//   Parallel-to-serial stage feeding an 8-stage shift register. Words from a
//   valid/ready producer are queued in serializer_fifo and sent MSB-first, one
//   bit per clock, on SerialOut. FrameStart flags the MSB cycle of each word.
//   Optional feature macro: BYTE_SERIALIZER_PARITY_EN
//     defined   -> an even-parity bit follows every word (DATA_W+1 bit-times)
//     undefined -> no parity bit (DATA_W bit-times)
//   GAP idle bit-times follow every word in both builds.
//   Ports:
//     Clk         in   1        rising-edge clock
//     Reset       in   1        synchronous active-high reset
//     DataIn      in   DATA_W   parallel word from producer
//     DataValid   in   1        DataIn valid
//     DataReady   out  1        FIFO can accept (low while Reset is high)
//     SerialOut   out  1        serial bit stream
//     FrameStart  out  1        high while SerialOut carries a word's MSB
//     Busy        out  1        FIFO non-empty or FSM not idle
// ----------------------------------------------------------------------------
module byte_serializer
    import byte_serializer_pkg::*;
#(
    parameter int   DATA_W   = 8,
    parameter int   DEPTH    = 4,
    parameter int   GAP      = 0,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              DataValid,
    output logic              DataReady,
    output logic              SerialOut,
    output logic              FrameStart,
    output logic              Busy
);

    localparam int BW = cnt_width(DATA_W - 1);
    localparam int GW = cnt_width(GAP);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
    localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] next_shift;
    logic [BW-1:0]     bit_cnt;
    logic [BW-1:0]     next_bit;
    logic [GW-1:0]     gap_cnt;
    logic [GW-1:0]     next_gap;
`ifdef BYTE_SERIALIZER_PARITY_EN
    logic              parity;
    logic              next_parity;
`endif

    logic              word_end;
    logic              want_next;
    logic              fifo_push;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;

    // Reset gates DataReady directly so the producer sees "not ready" for the
    // whole time Reset is held, even though the FIFO itself is already empty.
    assign DataReady = !fifo_full && !Reset;
    assign fifo_push = DataValid && DataReady;

    serializer_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (Clk),
        .reset   (Reset),
        .push    (fifo_push),
        .wr_data (DataIn),
        .pop     (fifo_pop),
        .rd_data (fifo_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // State, shift register and counters. Reset throws away any word in
    // flight; nothing partial is ever completed.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= S_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
`ifdef BYTE_SERIALIZER_PARITY_EN
            parity    <= 1'b0;
`endif
        end else begin
            state     <= next_state;
            shift_reg <= next_shift;
            bit_cnt   <= next_bit;
            gap_cnt   <= next_gap;
`ifdef BYTE_SERIALIZER_PARITY_EN
            parity    <= next_parity;
`endif
        end
    end

    // Next-state logic. word_end means the data (and parity) bits of a word
    // are finished; want_next means "act as IDLE on this edge", which lets
    // the next queued word load on the same edge the previous one ends so
    // the stream has no idle bit between words when GAP is 0.
    always_comb begin
        next_state = state;
        next_shift = shift_reg;
        next_bit   = bit_cnt;
        next_gap   = gap_cnt;
        fifo_pop   = 1'b0;
        word_end   = 1'b0;
        want_next  = 1'b0;
`ifdef BYTE_SERIALIZER_PARITY_EN
        next_parity = parity;
`endif

        case (state)
            S_SHIFT: begin
                next_shift = {shift_reg[DATA_W-2:0], 1'b0};
                next_bit   = bit_cnt - 1'b1;
`ifdef BYTE_SERIALIZER_PARITY_EN
                next_parity = parity ^ shift_reg[DATA_W-1];
`endif
                if (bit_cnt == '0) begin
`ifdef BYTE_SERIALIZER_PARITY_EN
                    next_state = S_PARITY;
`else
                    word_end = 1'b1;
`endif
                end
            end
            S_PARITY: begin
                word_end = 1'b1;
            end
            S_GAP: begin
                if (gap_cnt == '0) begin
                    want_next = 1'b1;
                end else begin
                    next_gap = gap_cnt - 1'b1;
                end
            end
            default: begin
                want_next = 1'b1;
            end
        endcase

        if (word_end) begin
            if (GAP > 0) begin
                next_state = S_GAP;
                next_gap   = GAP_LAST;
            end else begin
                want_next = 1'b1;
            end
        end

        if (want_next) begin
            if (!fifo_empty) begin
                fifo_pop   = 1'b1;
                next_state = S_SHIFT;
                next_shift = fifo_data;
                next_bit   = BIT_LAST;
`ifdef BYTE_SERIALIZER_PARITY_EN
                next_parity = 1'b0;
`endif
            end else begin
                next_state = S_IDLE;
            end
        end
    end

    // Line drive: data bits in SHIFT, the accumulated even parity in PARITY,
    // and the idle level everywhere else.
    always_comb begin
        SerialOut = IDLE_BIT;
        if (state == S_SHIFT) begin
            SerialOut = shift_reg[DATA_W-1];
        end
`ifdef BYTE_SERIALIZER_PARITY_EN
        if (state == S_PARITY) begin
            SerialOut = parity;
        end
`endif
    end

    assign FrameStart = (state == S_SHIFT) && (bit_cnt == BIT_LAST);
    assign Busy       = (fifo_count != '0) || (state != S_IDLE);

endmodule
